// File: rtl/flash_controller_pkg.sv
// Shared definitions for the NAND page-read loop controller: FSM states,
// NAND command bytes and the address-cycle byte selector.
package flash_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD1,
        ADDR,
        CMD2,
        WAIT_R,
        READ,
        DONE
    } state_e;

    localparam logic [7:0] CMD_READ     = 8'h00;
    localparam logic [7:0] CMD_CONFIRM  = 8'h30;
    localparam int         N_ADDR       = 5;
    localparam int         PHASE_CYCLES = 2;

    // Address cycles: two column bytes (fixed 0), then row bytes LSB first.
    function automatic logic [7:0] addr_byte(input logic [2:0] idx, input logic [23:0] row);
        case (idx)
            3'd2:    return row[7:0];
            3'd3:    return row[15:8];
            3'd4:    return row[23:16];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nand_ddr_capture.sv
// DDR capture of the NAND data bus: rising-edge bytes with DQS high and
// falling-edge bytes with DQS low, both gated by an enable.
module nand_ddr_capture (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] dq_i,
    input  logic       dqs_i,
    output logic [7:0] debug_o,
    output logic [7:0] debug90_o
);

    logic [7:0] debug_q;
    logic [7:0] debug90_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            debug_q <= 8'h00;
        end else if (en_i && dqs_i == 1'b1) begin
            debug_q <= dq_i;
        end
    end

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            debug90_q <= 8'h00;
        end else if (en_i && dqs_i == 1'b0) begin
            debug90_q <= dq_i;
        end
    end

    assign debug_o   = debug_q;
    assign debug90_o = debug90_q;

endmodule

// File: rtl/flash_controller.sv
// Bring-up NAND read loop: idle wait, page-read command/address sequence,
// array-read wait, then DDR burst capture onto two debug byte ports.
module flash_controller
    import flash_controller_pkg::*;
#(
    parameter int          IDLE_CYCLES = 100,
    parameter int          TR_CYCLES   = 32,
    parameter int          READ_BYTES  = 4,
    parameter int          CE_SEL      = 0,
    parameter logic [23:0] ROW_ADDR    = 24'h0
) (
    input  logic       CLK_sysClk,
    input  logic       RST_sysRst,
    inout  wire  [7:0] DQ,
    inout  wire        DQS,
    output logic       NAND_CLK,
    output logic       CLE,
    output logic       ALE,
    output logic       WRN,
    output logic       WPN,
    output logic [1:0] CEN,
    output logic [7:0] DEBUG,
    output logic [7:0] DEBUG90
);

    localparam int         CNT_W      = 16;
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(PHASE_CYCLES * N_ADDR - 1);
    localparam logic [CNT_W-1:0] TR_LAST    = CNT_W'(TR_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_BYTES - 1);
    localparam logic [1:0]       CEN_ACTIVE = (CE_SEL == 1) ? 2'b01 : 2'b10;

    state_e           state_q, state_d, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
    logic             nand_clk_q;
    logic             cle_q, cle_d;
    logic             ale_q, ale_d;
    logic             wrn_q, wrn_d;
    logic             wpn_q;
    logic [1:0]       cen_q, cen_d;
    logic             dq_oe_q, dq_oe_d;
    logic [7:0]       dq_q, dq_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        cnt_last  = PHASE_LAST;
        state_nxt = IDLE;
        case (state_q)
            IDLE:    begin cnt_last = IDLE_LAST;  state_nxt = CMD1;   end
            CMD1:    begin cnt_last = PHASE_LAST; state_nxt = ADDR;   end
            ADDR:    begin cnt_last = ADDR_LAST;  state_nxt = CMD2;   end
            CMD2:    begin cnt_last = PHASE_LAST; state_nxt = WAIT_R; end
            WAIT_R:  begin cnt_last = TR_LAST;    state_nxt = READ;   end
            READ:    begin cnt_last = READ_LAST;  state_nxt = DONE;   end
            DONE:    begin cnt_last = PHASE_LAST; state_nxt = IDLE;   end
            default: begin cnt_last = PHASE_LAST; state_nxt = IDLE;   end
        endcase
        if (cnt_q == cnt_last) begin
            cnt_d   = '0;
            state_d = state_nxt;
        end

        // Pin values are decoded from the next state so they register in
        // lockstep with the state transition.
        cle_d   = 1'b0;
        ale_d   = 1'b0;
        wrn_d   = 1'b1;
        dq_oe_d = 1'b0;
        dq_d    = 8'h00;
        cen_d   = (state_d == IDLE) ? 2'b11 : CEN_ACTIVE;
        case (state_d)
            CMD1: begin
                cle_d   = 1'b1;
                dq_oe_d = 1'b1;
                dq_d    = CMD_READ;
            end
            ADDR: begin
                ale_d   = 1'b1;
                dq_oe_d = 1'b1;
                dq_d    = addr_byte(cnt_d[3:1], ROW_ADDR);
            end
            CMD2: begin
                cle_d   = 1'b1;
                dq_oe_d = 1'b1;
                dq_d    = CMD_CONFIRM;
            end
            READ: begin
                cle_d = 1'b1;
                ale_d = 1'b1;
                wrn_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_sysClk or posedge RST_sysRst) begin
        if (RST_sysRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nand_clk_q <= 1'b0;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            wrn_q      <= 1'b1;
            wpn_q      <= 1'b0;
            cen_q      <= 2'b11;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nand_clk_q <= ~nand_clk_q;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            wrn_q      <= wrn_d;
            wpn_q      <= 1'b1;
            cen_q      <= cen_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    // Output data needs no reset: the bus is released while in reset.
    always_ff @(posedge CLK_sysClk) begin
        dq_q <= dq_d;
    end

    assign DQ  = dq_oe_q ? dq_q : 8'hzz;
    assign DQS = 1'bz;

    assign NAND_CLK = nand_clk_q;
    assign CLE      = cle_q;
    assign ALE      = ale_q;
    assign WRN      = wrn_q;
    assign WPN      = wpn_q;
    assign CEN      = cen_q;

    nand_ddr_capture u_capture (
        .clk_i     (CLK_sysClk),
        .rst_i     (RST_sysRst),
        .en_i      (state_q == READ),
        .dq_i      (DQ),
        .dqs_i     (DQS),
        .debug_o   (DEBUG),
        .debug90_o (DEBUG90)
    );

endmodule

// File: tb/tb_flash_controller.sv
// Directed bench for flash_controller: reset values, command/address bytes,
// DDR capture, idle-bus hold, loop period, mid-sequence reset and CE_SEL=1.
module tb_flash_controller;

    localparam int IDLE_C = 100;
    localparam int TR_C   = 32;
    localparam int RB_C   = 4;
    // loop period = IDLE + CMD1 + ADDR + CMD2 + WAIT_R + READ + DONE
    localparam int LOOP_C = IDLE_C + 2 + 10 + 2 + TR_C + RB_C + 2;

    logic       clk;
    logic       rst;
    logic       tb_oe, tb_dqs_oe, tb_dqs;
    logic [7:0] tb_dq;
    wire  [7:0] DQ;
    wire        DQS;
    logic       NAND_CLK, CLE, ALE, WRN, WPN;
    logic [1:0] CEN;
    logic [7:0] DEBUG, DEBUG90;

    wire  [7:0] DQ_b;
    wire        DQS_b;
    logic       NAND_CLK_b, CLE_b, ALE_b, WRN_b, WPN_b;
    logic [1:0] CEN_b;
    logic [7:0] DEBUG_b, DEBUG90_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    int at;

    logic [7:0] exp_dq  [7] = '{8'h00, 8'h00, 8'h00, 8'h56, 8'h34, 8'h12, 8'h30};
    logic       exp_cle [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_ale [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    assign DQ  = tb_oe ? tb_dq : 8'hzz;
    assign DQS = tb_dqs_oe ? tb_dqs : 1'bz;

    flash_controller #(
        .IDLE_CYCLES(IDLE_C), .TR_CYCLES(TR_C), .READ_BYTES(RB_C),
        .CE_SEL(0), .ROW_ADDR(24'h123456)
    ) dut (
        .CLK_sysClk(clk), .RST_sysRst(rst), .DQ(DQ), .DQS(DQS),
        .NAND_CLK(NAND_CLK), .CLE(CLE), .ALE(ALE), .WRN(WRN), .WPN(WPN),
        .CEN(CEN), .DEBUG(DEBUG), .DEBUG90(DEBUG90)
    );

    flash_controller #(
        .IDLE_CYCLES(IDLE_C), .TR_CYCLES(TR_C), .READ_BYTES(RB_C),
        .CE_SEL(1), .ROW_ADDR(24'h123456)
    ) dut_b (
        .CLK_sysClk(clk), .RST_sysRst(rst), .DQ(DQ_b), .DQS(DQS_b),
        .NAND_CLK(NAND_CLK_b), .CLE(CLE_b), .ALE(ALE_b), .WRN(WRN_b), .WPN(WPN_b),
        .CEN(CEN_b), .DEBUG(DEBUG_b), .DEBUG90(DEBUG90_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cen_fall(input int limit, output int fall_at);
        fall_at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (CEN[0] == 1'b0) begin
                fall_at = cyc;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; tb_oe = 1'b0; tb_dq = 8'h00; tb_dqs_oe = 1'b0; tb_dqs = 1'b0;
        #202;
        check("rst_cen", 32'(CEN), 32'h3);
        check("rst_cen_b", 32'(CEN_b), 32'h3);
        check("rst_wpn", 32'(WPN), 32'h0);
        check("rst_debug", 32'(DEBUG), 32'h0);
        check("rst_debug90", 32'(DEBUG90), 32'h0);
        check("rst_ctl", 32'({NAND_CLK, CLE, ALE, WRN}), 32'h1);
        tb_oe = 1'b1; tb_dq = 8'h5A;
        #1 check("rst_dq_released", 32'(DQ), 32'h5A);
        tb_oe = 1'b0;
        rst = 1'b0;

        step();
        check("wpn_after_release", 32'(WPN), 32'h1);
        wait_cen_fall(200, at);
        check("first_cen_fall", 32'(at), 32'(IDLE_C));
        check("cen_sel0", 32'(CEN), 32'h2);
        check("cen_sel1", 32'(CEN_b), 32'h1);

        // each phase: NAND_CLK rises on the second half, where the NAND latches
        for (int p = 0; p < 7; p++) begin
            step();
            check("phase_nclk", 32'(NAND_CLK), 32'h1);
            check("phase_dq", 32'(DQ), 32'(exp_dq[p]));
            check("phase_cle_ale", 32'({CLE, ALE}), 32'({exp_cle[p], exp_ale[p]}));
            step();
        end
        check("wait_r_bus", 32'({CLE, ALE, WRN}), 32'h1);

        at = -1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (WRN == 1'b0) begin
                at = cyc;
                break;
            end
        end
        check("read_entry", 32'(at), 32'(IDLE_C + 14 + TR_C));
        check("read_cle_ale", 32'({CLE, ALE}), 32'h3);

        tb_oe = 1'b1; tb_dqs_oe = 1'b1;
        tb_dq = 8'hDE; tb_dqs = 1'b1;
        step();
        check("cap_de", 32'(DEBUG), 32'hDE);
        tb_dq = 8'hAD; tb_dqs = 1'b0;
        @(negedge clk); #1;
        check("cap_ad", 32'(DEBUG90), 32'hAD);
        tb_dq = 8'hBE; tb_dqs = 1'b1;
        step();
        tb_dq = 8'hEF; tb_dqs = 1'b0;
        step();
        step();
        check("done_cyc", 32'(cyc), 32'(IDLE_C + 14 + TR_C + RB_C));
        check("done_bus", 32'({CLE, ALE, WRN, CEN[0]}), 32'h2);
        check("read_exit_debug", 32'(DEBUG), 32'hBE);
        check("read_exit_debug90", 32'(DEBUG90), 32'hEF);

        step();
        step();
        check("idle_cen", 32'(CEN), 32'h3);
        check("idle_cen_b", 32'(CEN_b), 32'h3);

        tb_dq = 8'hAA;
        for (int i = 0; i < 20; i++) begin
            tb_dqs = ~tb_dqs;
            step();
        end
        check("idle_hold_debug", 32'(DEBUG), 32'hBE);
        check("idle_hold_debug90", 32'(DEBUG90), 32'hEF);
        tb_oe = 1'b0; tb_dqs_oe = 1'b0;

        wait_cen_fall(200, at);
        check("loop_period", 32'(at), 32'(IDLE_C + LOOP_C));
        check("loop_cen_b", 32'(CEN_b), 32'h1);

        // third address byte (row LSB) occupies cycles 6-7 of the sequence
        for (int i = 0; i < 7; i++) step();
        check("addr_before_rst", 32'({ALE, DQ}), 32'h156);
        #1 rst = 1'b1;
        #1;
        check("midrst_cen", 32'(CEN), 32'h3);
        check("midrst_ale", 32'(ALE), 32'h0);
        check("midrst_debug", 32'(DEBUG), 32'h0);
        tb_oe = 1'b1; tb_dq = 8'h00;
        #1 check("midrst_dq_released", 32'(DQ), 32'h00);
        tb_oe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        wait_cen_fall(200, at);
        check("restart_cen_fall", 32'(at), 32'(IDLE_C));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
